// File: rtl/sigmoid_share_sched.sv
// Round-robin scheduler sharing one SigmoidF unit among N_REQ requesters.
// Issued operands carry their requester ID through a tag pipe into a FWFT response FIFO.
module sigmoid_share_sched #(
    parameter int N_REQ      = 4,
    parameter int SIG_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_x,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           sig_x,
    input  logic [15:0]           sig_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_data,
    output logic                  busy
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int OCCW = $clog2(SIG_LAT + FIFO_DEPTH + 1);
    localparam int EW   = IDW + 16;

    logic [IDW-1:0]  r_ptr;
    logic [31:0]     r_sigX;
    logic [SIG_LAT-1:0] r_tagValid;
    logic [IDW-1:0]  r_tagId [SIG_LAT];

    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CNTW-1:0] r_count;

    logic            w_gntFound;
    logic [IDW-1:0]  w_gnt;
    logic [OCCW-1:0] w_inflight;
    logic [OCCW-1:0] w_occ;
    logic            w_canIssue;
    logic            w_transfer;
    logic [31:0]     w_selX;
    logic            w_push;
    logic [IDW-1:0]  w_pushId;
    logic            w_pop;
    logic [EW-1:0]   w_head;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_gntFound = 1'b0;
        w_gnt      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_gntFound && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
                w_gntFound = 1'b1;
                w_gnt      = IDW'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < SIG_LAT; i++) begin
            w_inflight = w_inflight + OCCW'(r_tagValid[i]);
        end
    end

    // Occupancy counts in-flight ops too, so every issued op is guaranteed a FIFO slot.
    assign w_occ      = w_inflight + OCCW'(r_count);
    assign w_canIssue = (w_occ < OCCW'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        if (!rst && w_gntFound && w_canIssue) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_transfer = |(req_valid & req_ready);
    assign w_selX     = req_x[32*int'(w_gnt) +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= IDW'(N_REQ - 1);
            r_sigX <= '0;
        end else if (w_transfer) begin
            r_ptr  <= w_gnt;
            r_sigX <= w_selX;
        end
    end

    assign sig_x = r_sigX;

    // Tag pipe mirrors the SigmoidF latency so the ID meets its result at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tagValid <= '0;
            for (int i = 0; i < SIG_LAT; i++) begin
                r_tagId[i] <= '0;
            end
        end else begin
            r_tagValid[0] <= w_transfer;
            r_tagId[0]    <= w_gnt;
            for (int i = 1; i < SIG_LAT; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagId[i]    <= r_tagId[i-1];
            end
        end
    end

    assign w_push   = r_tagValid[SIG_LAT-1];
    assign w_pushId = r_tagId[SIG_LAT-1];
    assign w_pop    = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {w_pushId, sig_out};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields are forced to zero when empty so stale memory never shows after reset.
    assign w_head    = r_mem[r_rdPtr];
    assign rsp_valid = (r_count != '0);
    assign rsp_id    = rsp_valid ? w_head[EW-1:16] : '0;
    assign rsp_data  = rsp_valid ? w_head[15:0]    : '0;
    assign busy      = (|r_tagValid) || rsp_valid;

endmodule

// File: tb/tb_sigmoid_share_sched.sv
// Randomized and directed bench for sigmoid_share_sched against a queue-based reference model.
// The SigmoidF stand-in returns x[15:0]+1 one edge after sig_x is loaded.
module tb_sigmoid_share_sched;

    localparam int N     = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    reqValid;
    logic [32*N-1:0] reqX;
    logic [N-1:0]    reqReady;
    logic [31:0]     sigX;
    logic [15:0]     sigOut;
    logic            rspValid;
    logic            rspReady;
    logic [IDW-1:0]  rspId;
    logic [15:0]     rspData;
    logic            busy;

    sigmoid_share_sched #(
        .N_REQ(N), .SIG_LAT(LAT), .FIFO_DEPTH(DEPTH), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_x(reqX), .req_ready(reqReady),
        .sig_x(sigX), .sig_out(sigOut),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_id(rspId), .rsp_data(rspData), .busy(busy)
    );

    always #5 clk = ~clk;

    assign sigOut = sigX[15:0] + 16'd1;

    typedef struct { int id; logic [31:0] x; int due; } flight_t;
    typedef struct { int id; logic [15:0] data; } rsp_t;

    flight_t     inflightQ[$];
    rsp_t        fifoQ[$];
    int          modelPtr;
    logic [31:0] modelSigX;
    int          cycleNum;
    logic        pendValid [N];
    logic [31:0] pendX [N];
    int          mode;
    int          lastGrant;
    int          checkCount;
    int          failCount;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cycleNum);
        end
    endtask

    function automatic int modelGrant();
        for (int k = 1; k <= N; k++) begin
            if (pendValid[(modelPtr + k) % N]) return (modelPtr + k) % N;
        end
        return -1;
    endfunction

    // Modes: 0 random, 1 all valid, 2 all valid with consumer stalled, 3 only reqs 1 and 3, 4 idle.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!pendValid[i]) begin
                if ((mode == 0 && $urandom_range(0, 1) == 1) || mode == 1 || mode == 2 ||
                    (mode == 3 && (i == 1 || i == 3))) begin
                    pendValid[i] = 1'b1;
                    pendX[i]     = $urandom;
                end
            end
        end
        if (mode == 0) rspReady = ($urandom_range(0, 99) < 65);
        else           rspReady = (mode != 2);
        for (int i = 0; i < N; i++) begin
            reqValid[i]       = pendValid[i];
            reqX[32*i +: 32]  = pendX[i];
        end
    endtask

    task automatic runCycle();
        int          g;
        int          occ;
        logic [N-1:0] expReady;
        logic        xfer;
        logic        pop;
        flight_t     f;
        rsp_t        r;
        applyStimulus();
        @(negedge clk);
        occ = inflightQ.size() + fifoQ.size();
        g   = modelGrant();
        expReady = '0;
        if (g >= 0 && occ < DEPTH) expReady[g] = 1'b1;
        checkOutput("req_ready", 32'(reqReady), 32'(expReady));
        checkOutput("rsp_valid", 32'(rspValid), 32'(fifoQ.size() > 0));
        if (fifoQ.size() > 0) begin
            checkOutput("rsp_id", 32'(rspId), fifoQ[0].id);
            checkOutput("rsp_data", 32'(rspData), 32'(fifoQ[0].data));
        end
        checkOutput("busy", 32'(busy), 32'(occ > 0));
        checkOutput("sig_x", sigX, modelSigX);
        xfer = (g >= 0) && (occ < DEPTH);
        pop  = (fifoQ.size() > 0) && rspReady;
        lastGrant = -1;
        for (int i = 0; i < N; i++) begin
            if (reqReady[i] && reqValid[i]) lastGrant = i;
        end
        @(posedge clk);
        cycleNum++;
        if (pop) void'(fifoQ.pop_front());
        while (inflightQ.size() > 0 && inflightQ[0].due == cycleNum) begin
            f      = inflightQ.pop_front();
            r.id   = f.id;
            r.data = f.x[15:0] + 16'd1;
            fifoQ.push_back(r);
        end
        if (xfer) begin
            f.id  = g;
            f.x   = pendX[g];
            f.due = cycleNum + LAT;
            inflightQ.push_back(f);
            modelSigX    = pendX[g];
            modelPtr     = g;
            pendValid[g] = 1'b0;
        end
        #1;
    endtask

    // Asserts reset mid-cycle, checks the outputs respond without waiting for a clock edge.
    task automatic doReset(input bit clearPend);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
        checkOutput("rst_sig_x", sigX, 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_id", 32'(rspId), 32'd0);
        checkOutput("rst_rsp_data", 32'(rspData), 32'd0);
        inflightQ.delete();
        fifoQ.delete();
        modelPtr  = N - 1;
        modelSigX = '0;
        if (clearPend) begin
            for (int i = 0; i < N; i++) pendValid[i] = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int xfers;
        checkCount = 0;
        failCount  = 0;
        cycleNum   = 0;
        modelPtr   = N - 1;
        modelSigX  = '0;
        rst        = 1'b1;
        reqValid   = '0;
        reqX       = '0;
        rspReady   = 1'b0;
        for (int i = 0; i < N; i++) begin
            pendValid[i] = 1'b0;
            pendX[i]     = '0;
        end
        @(posedge clk);
        #1;
        checkOutput("init_busy", 32'(busy), 32'd0);
        checkOutput("init_rsp_valid", 32'(rspValid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of traffic, then fairness from requester 0.
        mode = 1;
        repeat (3) runCycle();
        doReset(1'b0);
        for (int k = 0; k < 5; k++) begin
            runCycle();
            checkOutput("rr_grant", 32'(lastGrant), 32'(k % N));
        end
        repeat (4) runCycle();

        // Single request from requester 2.
        doReset(1'b1);
        mode = 4;
        pendValid[2] = 1'b1;
        pendX[2]     = 32'h0000_0010;
        runCycle();
        checkOutput("single_sig_x", sigX, 32'h0000_0010);
        runCycle();
        checkOutput("single_rsp_valid", 32'(rspValid), 32'd1);
        checkOutput("single_rsp_id", 32'(rspId), 32'd2);
        checkOutput("single_rsp_data", 32'(rspData), 32'h0011);
        repeat (3) runCycle();

        // Consumer stalled: issue must stop once the FIFO is fully reserved.
        doReset(1'b1);
        mode  = 2;
        xfers = 0;
        repeat (10) begin
            runCycle();
            if (lastGrant >= 0) xfers++;
        end
        checkOutput("bp_transfers", 32'(xfers), 32'd4);
        checkOutput("bp_ready_held", 32'(reqReady), 32'd0);
        mode = 1;
        repeat (10) runCycle();

        // Sparse requesters with wrap-around, including a negative operand.
        doReset(1'b1);
        mode = 3;
        pendValid[1] = 1'b1;
        pendX[1]     = 32'hFFFF_8000;
        runCycle();
        checkOutput("sparse_grant0", 32'(lastGrant), 32'd1);
        runCycle();
        checkOutput("sparse_grant1", 32'(lastGrant), 32'd3);
        checkOutput("sparse_neg_id", 32'(rspId), 32'd1);
        checkOutput("sparse_neg_data", 32'(rspData), 32'h8001);
        for (int k = 0; k < 6; k++) begin
            runCycle();
            checkOutput("sparse_alt", 32'(lastGrant), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Reset with work both in flight and queued; nothing may come back.
        doReset(1'b1);
        mode = 2;
        repeat (3) runCycle();
        doReset(1'b1);
        mode = 4;
        repeat (4) runCycle();
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_rsp_valid", 32'(rspValid), 32'd0);

        // Long randomized run.
        mode = 0;
        repeat (400) runCycle();
        mode = 4;
        repeat (10) runCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
